// File: rtl/pwm_medidor.sv
// Purpose : measures the period and high time of an asynchronous PWM input, in clk ticks, and flags stuck inputs.
// Latency : a report (valido) comes 2 clk after the rising edge that closes the period is first sampled.
// Backpres: none; valido is a one-cycle strobe and the consumer must take periodo/alto when it is high.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   pwm_in     asynchronous PWM input (synchronised internally)
//   periodo    last measured period, clk ticks (held between reports)
//   alto       last measured high time, clk ticks (held between reports)
//   valido     one-cycle strobe: periodo/alto just updated
//   pegado_hi  input stuck high (timeout in the high phase)
//   pegado_lo  input stuck low (timeout in the low phase)
module pwm_medidor #(
    parameter int W       = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pwm_in,
    output logic [W-1:0] periodo,
    output logic [W-1:0] alto,
    output logic         valido,
    output logic         pegado_hi,
    output logic         pegado_lo
);

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        ALTO   = 2'd1,
        BAJO   = 2'd2
    } estado_t;

    localparam logic [W-1:0] TMO = W'(TIMEOUT);
    localparam logic [W-1:0] UNO = W'(1);

    // s1/s2 resolve metastability; s3 is the previous synchronised sample for edge detection.
    logic s1, s2, s3;
    logic sube, baja;

    estado_t      estado, estado_n;
    logic [W-1:0] cnt_per, cnt_per_n;
    logic [W-1:0] cnt_hi, cnt_hi_n;
    // Set while the first period after ESPERA is in flight; that period may have
    // started from a spurious or partial edge, so it is measured but not reported.
    logic         primero, primero_n;

    logic [W-1:0] periodo_n, alto_n;
    logic         valido_n, pegado_hi_n, pegado_lo_n;
    logic [W-1:0] per_inc;

    assign sube = s2 & ~s3;
    assign baja = ~s2 & s3;

    // Saturating increment: an edge arriving on the timeout cycle wins over the
    // timeout, so cnt_per can sit at TIMEOUT for a cycle and must not wrap.
    assign per_inc = (cnt_per == TMO) ? cnt_per : cnt_per + UNO;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            estado    <= ESPERA;
            cnt_per   <= '0;
            cnt_hi    <= '0;
            primero   <= 1'b0;
            periodo   <= '0;
            alto      <= '0;
            valido    <= 1'b0;
            pegado_hi <= 1'b0;
            pegado_lo <= 1'b0;
        end else begin
            s1        <= pwm_in;
            s2        <= s1;
            s3        <= s2;
            estado    <= estado_n;
            cnt_per   <= cnt_per_n;
            cnt_hi    <= cnt_hi_n;
            primero   <= primero_n;
            periodo   <= periodo_n;
            alto      <= alto_n;
            valido    <= valido_n;
            pegado_hi <= pegado_hi_n;
            pegado_lo <= pegado_lo_n;
        end
    end

    always_comb begin
        estado_n    = estado;
        cnt_per_n   = cnt_per;
        cnt_hi_n    = cnt_hi;
        primero_n   = primero;
        periodo_n   = periodo;
        alto_n      = alto;
        valido_n    = 1'b0;
        pegado_hi_n = pegado_hi;
        pegado_lo_n = pegado_lo;

        unique case (estado)
            ESPERA: begin
                cnt_per_n = '0;
                cnt_hi_n  = '0;
                if (sube) begin
                    estado_n  = ALTO;
                    cnt_per_n = UNO;
                    cnt_hi_n  = UNO;
                    primero_n = 1'b1;
                end
            end

            ALTO: begin
                if (baja) begin
                    estado_n  = BAJO;
                    cnt_per_n = per_inc;
                end else if (cnt_per == TMO) begin
                    estado_n    = ESPERA;
                    cnt_per_n   = '0;
                    cnt_hi_n    = '0;
                    primero_n   = 1'b0;
                    periodo_n   = TMO;
                    alto_n      = TMO;
                    valido_n    = 1'b1;
                    pegado_hi_n = 1'b1;
                    pegado_lo_n = 1'b0;
                end else begin
                    cnt_per_n = per_inc;
                    // cnt_hi never exceeds cnt_per, so it cannot overflow here.
                    cnt_hi_n  = cnt_hi + UNO;
                end
            end

            BAJO: begin
                if (sube) begin
                    if (!primero) begin
                        periodo_n   = cnt_per;
                        alto_n      = cnt_hi;
                        valido_n    = 1'b1;
                        pegado_hi_n = 1'b0;
                        pegado_lo_n = 1'b0;
                    end
                    primero_n = 1'b0;
                    estado_n  = ALTO;
                    cnt_per_n = UNO;
                    cnt_hi_n  = UNO;
                end else if (cnt_per == TMO) begin
                    estado_n    = ESPERA;
                    cnt_per_n   = '0;
                    cnt_hi_n    = '0;
                    primero_n   = 1'b0;
                    periodo_n   = TMO;
                    alto_n      = '0;
                    valido_n    = 1'b1;
                    pegado_hi_n = 1'b0;
                    pegado_lo_n = 1'b1;
                end else begin
                    cnt_per_n = per_inc;
                end
            end

            default: begin
                estado_n  = ESPERA;
                cnt_per_n = '0;
                cnt_hi_n  = '0;
                primero_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_medidor.sv
// Purpose : directed self-checking bench for pwm_medidor (steady duty, extreme duty, stuck high/low, mid-run reset).
// Latency : checks sample outputs 1 time unit after the rising clk edge; reports are collected on the falling edge.
// Backpres: not applicable; valido pulses are counted and their payload captured as they occur.
module tb_pwm_medidor;

    localparam int W       = 12;
    localparam int TIMEOUT = 4095;

    logic         clk;
    logic         rst;
    logic         pwm_in;
    logic [W-1:0] periodo;
    logic [W-1:0] alto;
    logic         valido;
    logic         pegado_hi;
    logic         pegado_lo;

    int checks = 0;
    int errors = 0;

    // Report monitor state.
    int           nval     = 0;
    int           dbl      = 0;
    int           cyc      = 0;
    int           last_cyc = 0;
    int           gap      = 0;
    logic         prev_val = 1'b0;
    logic [W-1:0] last_per  = '0;
    logic [W-1:0] last_alto = '0;

    pwm_medidor #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .periodo   (periodo),
        .alto      (alto),
        .valido    (valido),
        .pegado_hi (pegado_hi),
        .pegado_lo (pegado_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valido) begin
            nval      = nval + 1;
            gap       = cyc - last_cyc;
            last_cyc  = cyc;
            last_per  = periodo;
            last_alto = alto;
            if (prev_val) dbl = dbl + 1;
        end
        prev_val = valido;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic periods(input int h, input int l, input int n);
        repeat (n) begin
            pwm_in = 1'b1;
            tick(h);
            pwm_in = 1'b0;
            tick(l);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n0;
        rst    = 1'b1;
        pwm_in = 1'b0;
        tick(4);
        chk("rst_periodo",   32'(periodo),   0);
        chk("rst_alto",      32'(alto),      0);
        chk("rst_valido",    32'(valido),    0);
        chk("rst_pegado_hi", 32'(pegado_hi), 0);
        chk("rst_pegado_lo", 32'(pegado_lo), 0);
        rst = 1'b0;
        tick(5);

        // 32/32: rises 1..6; first rise arms, second closes the unreported first period.
        periods(32, 32, 6);
        chk("s32_count",   nval,             4);
        chk("s32_periodo", 32'(last_per),    64);
        chk("s32_alto",    32'(last_alto),   32);
        chk("s32_gap",     gap,              64);
        chk("s32_single",  dbl,              0);

        // Extreme duty; each rise reports the period that just closed.
        periods(63, 1, 2);
        chk("d63_periodo", 32'(last_per),  64);
        chk("d63_alto",    32'(last_alto), 63);
        n0 = nval;
        periods(1, 63, 1);
        chk("d1_inflight_count", nval - n0,      1);
        chk("d1_inflight_alto",  32'(last_alto), 63);
        periods(1, 63, 1);
        chk("d1_periodo", 32'(last_per),  64);
        chk("d1_alto",    32'(last_alto), 1);
        chk("d1_single",  dbl,            0);

        // Stuck high: the rise reports the last 1/63 period, then exactly one timeout report.
        pwm_in = 1'b1;
        tick(10);
        n0 = nval;
        tick(4990);
        chk("hi_count",     nval - n0,        1);
        chk("hi_periodo",   32'(last_per),    TIMEOUT);
        chk("hi_alto",      32'(last_alto),   TIMEOUT);
        chk("hi_pegado_hi", 32'(pegado_hi),   1);
        chk("hi_pegado_lo", 32'(pegado_lo),   0);

        // Recovery: fall, arm on the rise, skip the first period, report the next.
        n0 = nval;
        pwm_in = 1'b0;
        tick(32);
        periods(32, 32, 2);
        chk("rec_no_report", nval - n0,      0);
        chk("rec_flag_held", 32'(pegado_hi), 1);
        periods(32, 32, 1);
        chk("rec_count",   nval - n0,      1);
        chk("rec_flag",    32'(pegado_hi), 0);
        chk("rec_alto",    32'(last_alto), 32);
        chk("rec_periodo", 32'(last_per),  64);

        // Stuck low.
        n0 = nval;
        pwm_in = 1'b0;
        tick(5000);
        chk("lo_count",     nval - n0,        1);
        chk("lo_periodo",   32'(last_per),    TIMEOUT);
        chk("lo_alto",      32'(last_alto),   0);
        chk("lo_pegado_lo", 32'(pegado_lo),   1);
        chk("lo_pegado_hi", 32'(pegado_hi),   0);

        // Mid-run reset while high: outputs clear immediately, partial period discarded.
        periods(32, 32, 2);
        pwm_in = 1'b1;
        tick(10);
        rst = 1'b1;
        #1;
        chk("mrst_periodo",   32'(periodo),   0);
        chk("mrst_alto",      32'(alto),      0);
        chk("mrst_valido",    32'(valido),    0);
        chk("mrst_pegado_lo", 32'(pegado_lo), 0);
        chk("mrst_pegado_hi", 32'(pegado_hi), 0);
        tick(3);
        rst = 1'b0;
        n0 = nval;
        tick(10);
        pwm_in = 1'b0;
        tick(32);
        periods(32, 32, 1);
        chk("mrst_first_full", nval - n0, 0);
        periods(32, 32, 1);
        chk("mrst_second_full", nval - n0,      1);
        chk("mrst_alto",        32'(last_alto), 32);
        chk("mrst_per",         32'(last_per),  64);
        chk("mrst_single",      dbl,            0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
